iob_merge_rr_inv: RTL and testbench

//  Parametrised N-master native-bus merge in front of the L2 cache. Round-robin arbitration,
//  one outstanding transaction at a time. Integrated invalidate sequencer: holds new grants,

---
 rtl/iob_merge_rr_inv_pkg.sv | 19 +
 rtl/iob_merge_rr_inv_arb.sv | 33 +++
 rtl/iob_merge_rr_inv.sv | 147 ++++++++++++++
 tb/tb_iob_merge_rr_inv.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_merge_rr_inv_pkg.sv
// Shared types for the round-robin native-bus merge with its invalidate sequencer.
// Holds the FSM state encoding and the grant-index width helper.
package iob_merge_rr_inv_pkg;

  localparam int MAX_MASTERS = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_BUSY      = 2'd1,
    ST_INV_WAIT  = 2'd2,
    ST_INV_PULSE = 2'd3
  } state_e;

  // A single master still needs a 1-bit index so the grant register is never zero-width.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/iob_merge_rr_inv_arb.sv
// Round-robin pick: first requester after last_i, wrapping modulo N.
// Latency: combinational. Backpressure: none, pure function of req_i/last_i.
// Grant is both one-hot and encoded.
module iob_merge_rr_inv_arb
  import iob_merge_rr_inv_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic             vld_o,
  output logic [IDX_W-1:0] idx_o,
  output logic [N-1:0]     oh_o
);

  always_comb begin
    int c;
    c     = 0;
    vld_o = 1'b0;
    idx_o = '0;
    oh_o  = '0;
    for (int k = 1; k <= N; k++) begin
      c = (int'(last_i) + k) % N;
      if (!vld_o && req_i[c]) begin
        vld_o   = 1'b1;
        idx_o   = IDX_W'(c);
        oh_o[c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/iob_merge_rr_inv.sv
// N-master native-bus merge to L2, one outstanding transaction, with an invalidate sequencer.
// Latency: request->s_valid 1 cycle; s_ready->m_ready 0 cycles. Backpressure: masters hold m_valid until m_ready.
// Optional MERGE_CNT_EN adds saturating per-master grant counters (cnt_grant, cnt_clr).
module iob_merge_rr_inv
  import iob_merge_rr_inv_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 24,
  parameter int DATA_W    = 32
`ifdef MERGE_CNT_EN
  ,
  parameter int CNT_W     = 16
`endif
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_MASTERS-1:0]          m_valid,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
  input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
  input  logic [N_MASTERS*DATA_W/8-1:0] m_wstrb,
  output logic [N_MASTERS*DATA_W-1:0]   m_rdata,
  output logic [N_MASTERS-1:0]          m_ready,
  output logic                          s_valid,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [DATA_W-1:0]             s_wdata,
  output logic [DATA_W/8-1:0]           s_wstrb,
  input  logic [DATA_W-1:0]             s_rdata,
  input  logic                          s_ready,
  input  logic                          inv_req,
  input  logic                          wtb_empty_in,
  output logic                          force_inv_out,
  output logic                          inv_busy
`ifdef MERGE_CNT_EN
  ,
  input  logic                          cnt_clr,
  output logic [N_MASTERS*CNT_W-1:0]    cnt_grant
`endif
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = idx_w(N_MASTERS);

  state_e                 state_q;
  logic [IDX_W-1:0]       grant_q;
  logic [N_MASTERS-1:0]   grant_oh_q;
  logic [IDX_W-1:0]       last_q;
  logic                   inv_pending_q;
  logic                   force_q;

  logic                   arb_vld;
  logic [IDX_W-1:0]       arb_idx;
  logic [N_MASTERS-1:0]   arb_oh;
  logic                   busy;
  logic                   done;

  iob_merge_rr_inv_arb #(
    .N     (N_MASTERS),
    .IDX_W (IDX_W)
  ) u_arb (
    .req_i  (m_valid),
    .last_i (last_q),
    .vld_o  (arb_vld),
    .idx_o  (arb_idx),
    .oh_o   (arb_oh)
  );

  assign busy          = (state_q == ST_BUSY);
  assign done          = busy & s_ready;
  assign force_inv_out = force_q;
  assign inv_busy      = inv_pending_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      grant_oh_q    <= '0;
      last_q        <= IDX_W'(N_MASTERS - 1);
      inv_pending_q <= 1'b0;
      force_q       <= 1'b0;
    end else begin
      force_q <= 1'b0;
      if (inv_req) inv_pending_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          // Invalidate beats a simultaneous request so no new write can slip in ahead of it.
          if (inv_pending_q || inv_req) begin
            state_q <= ST_INV_WAIT;
          end else if (arb_vld) begin
            grant_q    <= arb_idx;
            grant_oh_q <= arb_oh;
            state_q    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (s_ready) begin
            last_q  <= grant_q;
            state_q <= ST_IDLE;
          end
        end
        ST_INV_WAIT: begin
          if (wtb_empty_in) begin
            force_q <= 1'b1;
            state_q <= ST_INV_PULSE;
          end
        end
        ST_INV_PULSE: begin
          inv_pending_q <= 1'b0;
          state_q       <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    s_valid = 1'b0;
    s_addr  = '0;
    s_wdata = '0;
    s_wstrb = '0;
    if (busy) begin
      s_valid = m_valid[grant_q];
      s_addr  = m_addr[int'(grant_q)*ADDR_W +: ADDR_W];
      s_wdata = m_wdata[int'(grant_q)*DATA_W +: DATA_W];
      s_wstrb = m_wstrb[int'(grant_q)*STRB_W +: STRB_W];
    end
  end

  for (genvar g = 0; g < N_MASTERS; g++) begin : g_rsp
    assign m_ready[g]                  = done & grant_oh_q[g];
    assign m_rdata[g*DATA_W +: DATA_W] = m_ready[g] ? s_rdata : '0;
  end

`ifdef MERGE_CNT_EN
  for (genvar g = 0; g < N_MASTERS; g++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q;
    always_ff @(posedge clk) begin
      if (rst || cnt_clr) begin
        cnt_q <= '0;
      end else if (m_ready[g] && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
    assign cnt_grant[g*CNT_W +: CNT_W] = cnt_q;
  end
`endif

endmodule

// File: tb/tb_iob_merge_rr_inv.sv
// Directed bench for iob_merge_rr_inv with N_MASTERS=2: cycle table plus hand sequences.
// Counter checks build only with MERGE_CNT_EN.
module tb_iob_merge_rr_inv;

  localparam int N  = 2;
  localparam int AW = 24;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  localparam logic [AW-1:0] A0 = 24'h000040;
  localparam logic [AW-1:0] A1 = 24'h000100;
  localparam logic [DW-1:0] W0 = 32'h01234567;
  localparam logic [DW-1:0] W1 = 32'hDEADBEEF;
  localparam logic [SW-1:0] S0 = 4'h0;
  localparam logic [SW-1:0] S1 = 4'hF;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    m_valid;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_wdata;
  logic [N*SW-1:0] m_wstrb;
  logic [N*DW-1:0] m_rdata;
  logic [N-1:0]    m_ready;
  logic            s_valid;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wdata;
  logic [SW-1:0]   s_wstrb;
  logic [DW-1:0]   s_rdata;
  logic            s_ready;
  logic            inv_req;
  logic            wtb_empty_in;
  logic            force_inv_out;
  logic            inv_busy;
`ifdef MERGE_CNT_EN
  logic            cnt_clr;
  logic [N*4-1:0]  cnt_grant;
`endif

  assign m_addr  = {A1, A0};
  assign m_wdata = {W1, W0};
  assign m_wstrb = {S1, S0};

  always #5 clk = ~clk;

  iob_merge_rr_inv #(
    .N_MASTERS (N),
    .ADDR_W    (AW),
    .DATA_W    (DW)
`ifdef MERGE_CNT_EN
    ,
    .CNT_W     (4)
`endif
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .m_valid       (m_valid),
    .m_addr        (m_addr),
    .m_wdata       (m_wdata),
    .m_wstrb       (m_wstrb),
    .m_rdata       (m_rdata),
    .m_ready       (m_ready),
    .s_valid       (s_valid),
    .s_addr        (s_addr),
    .s_wdata       (s_wdata),
    .s_wstrb       (s_wstrb),
    .s_rdata       (s_rdata),
    .s_ready       (s_ready),
    .inv_req       (inv_req),
    .wtb_empty_in  (wtb_empty_in),
    .force_inv_out (force_inv_out),
    .inv_busy      (inv_busy)
`ifdef MERGE_CNT_EN
    ,
    .cnt_clr       (cnt_clr),
    .cnt_grant     (cnt_grant)
`endif
  );

  typedef struct {
    string         name;
    logic          rst;
    logic [N-1:0]  mv;
    logic          sr;
    logic          ir;
    logic          we;
    logic          sv;
    logic [AW-1:0] addr;
    logic [N-1:0]  mr;
    logic          fi;
    logic          ib;
  } vec_t;

  vec_t tbl[$];
  int   errs   = 0;
  int   checks = 0;

  function automatic void add(string nm, logic r, logic [N-1:0] mv, logic sr, logic ir,
                              logic we, logic sv, logic [AW-1:0] a, logic [N-1:0] mr,
                              logic fi, logic ib);
    vec_t v;
    v.name = nm; v.rst = r; v.mv = mv; v.sr = sr; v.ir = ir; v.we = we;
    v.sv = sv; v.addr = a; v.mr = mr; v.fi = fi; v.ib = ib;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    logic [N*DW-1:0] er;
    logic [DW-1:0]   ew;
    logic [SW-1:0]   es;
    logic            got;

    //   name        rst mv    sr ir we   sv addr mr    fi ib
    add("rst",        1, 2'b11, 0, 1, 1,  0, '0, 2'b00, 0, 0);
    add("t1_idle0",   0, 2'b11, 0, 0, 1,  0, '0, 2'b00, 0, 0);
    add("t1_g0a",     0, 2'b11, 0, 0, 1,  1, A0, 2'b00, 0, 0);
    add("t1_g0b",     0, 2'b11, 0, 0, 1,  1, A0, 2'b00, 0, 0);
    add("t1_g0done",  0, 2'b11, 1, 0, 1,  1, A0, 2'b01, 0, 0);
    add("t1_idle1",   0, 2'b11, 0, 0, 1,  0, '0, 2'b00, 0, 0);
    add("t1_g1a",     0, 2'b11, 0, 0, 1,  1, A1, 2'b00, 0, 0);
    add("t1_g1b",     0, 2'b11, 0, 0, 1,  1, A1, 2'b00, 0, 0);
    add("t1_g1done",  0, 2'b11, 1, 0, 1,  1, A1, 2'b10, 0, 0);
    add("t1_idle2",   0, 2'b11, 0, 0, 1,  0, '0, 2'b00, 0, 0);
    add("t1_g0c",     0, 2'b11, 0, 0, 1,  1, A0, 2'b00, 0, 0);
    add("t1_g0d",     0, 2'b11, 0, 0, 1,  1, A0, 2'b00, 0, 0);
    add("t1_g0done2", 0, 2'b11, 1, 0, 1,  1, A0, 2'b01, 0, 0);
    add("t1_idle3",   0, 2'b11, 0, 0, 1,  0, '0, 2'b00, 0, 0);
    add("t1_g1c",     0, 2'b11, 0, 0, 1,  1, A1, 2'b00, 0, 0);
    add("t1_g1d",     0, 2'b11, 0, 0, 1,  1, A1, 2'b00, 0, 0);
    add("t1_g1done2", 0, 2'b11, 1, 0, 1,  1, A1, 2'b10, 0, 0);
    add("t2_idle",    0, 2'b10, 0, 0, 1,  0, '0, 2'b00, 0, 0);
    add("t2_busy",    0, 2'b10, 1, 0, 1,  1, A1, 2'b10, 0, 0);
    add("t2_stray",   0, 2'b00, 1, 0, 1,  0, '0, 2'b00, 0, 0);
    add("t3_idle",    0, 2'b01, 0, 0, 0,  0, '0, 2'b00, 0, 0);
    add("t3_inv",     0, 2'b01, 0, 1, 0,  1, A0, 2'b00, 0, 0);
    add("t3_done",    0, 2'b01, 1, 0, 0,  1, A0, 2'b01, 0, 1);
    add("t3_hold",    0, 2'b11, 0, 0, 0,  0, '0, 2'b00, 0, 1);
    add("t3_wait1",   0, 2'b11, 0, 1, 0,  0, '0, 2'b00, 0, 1);
    add("t3_wait2",   0, 2'b11, 0, 0, 0,  0, '0, 2'b00, 0, 1);
    add("t3_wait3",   0, 2'b11, 0, 0, 0,  0, '0, 2'b00, 0, 1);
    add("t3_wait4",   0, 2'b11, 0, 0, 0,  0, '0, 2'b00, 0, 1);
    add("t3_empty",   0, 2'b11, 0, 0, 1,  0, '0, 2'b00, 0, 1);
    add("t3_pulse",   0, 2'b11, 0, 0, 1,  0, '0, 2'b00, 1, 1);
    add("t3_resume",  0, 2'b11, 0, 0, 1,  0, '0, 2'b00, 0, 0);
    add("t3_g1",      0, 2'b11, 1, 0, 1,  1, A1, 2'b10, 0, 0);
    add("t4_req",     0, 2'b01, 0, 1, 1,  0, '0, 2'b00, 0, 0);
    add("t4_c1",      0, 2'b01, 0, 0, 1,  0, '0, 2'b00, 0, 1);
    add("t4_c2",      0, 2'b01, 0, 0, 1,  0, '0, 2'b00, 1, 1);
    add("t4_c3",      0, 2'b01, 0, 0, 1,  0, '0, 2'b00, 0, 0);
    add("t4_c4",      0, 2'b01, 1, 0, 1,  1, A0, 2'b01, 0, 0);
    add("t5_idle",    0, 2'b10, 0, 0, 1,  0, '0, 2'b00, 0, 0);
    add("t5_rst",     1, 2'b11, 0, 0, 1,  1, A1, 2'b00, 0, 0);
    add("t5_after",   0, 2'b11, 1, 0, 1,  0, '0, 2'b00, 0, 0);
    add("t5_g0",      0, 2'b11, 0, 0, 1,  1, A0, 2'b00, 0, 0);
    add("t5_done",    0, 2'b11, 1, 0, 1,  1, A0, 2'b01, 0, 0);
    add("end",        0, 2'b00, 0, 0, 1,  0, '0, 2'b00, 0, 0);

    rst = 1'b1; m_valid = '0; s_rdata = '0; s_ready = 1'b0;
    inv_req = 1'b0; wtb_empty_in = 1'b1;
`ifdef MERGE_CNT_EN
    cnt_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;

    foreach (tbl[k]) begin
      rst          = tbl[k].rst;
      m_valid      = tbl[k].mv;
      s_ready      = tbl[k].sr;
      inv_req      = tbl[k].ir;
      wtb_empty_in = tbl[k].we;
      s_rdata      = 32'hC0DE0000 | 32'(k);
      @(negedge clk);
      ew = (tbl[k].addr == A1) ? W1 : (tbl[k].addr == A0) ? W0 : '0;
      es = (tbl[k].addr == A1) ? S1 : '0;
      er = '0;
      if (tbl[k].mr[0]) er[DW-1:0]    = s_rdata;
      if (tbl[k].mr[1]) er[2*DW-1:DW] = s_rdata;
      chk({tbl[k].name, "/req"}, {s_valid, s_addr, s_wdata, s_wstrb},
          {tbl[k].sv, tbl[k].addr, ew, es});
      chk({tbl[k].name, "/rsp"}, {m_ready, m_rdata}, {tbl[k].mr, er});
      chk({tbl[k].name, "/inv"}, {force_inv_out, inv_busy}, {tbl[k].fi, tbl[k].ib});
      @(posedge clk);
      #1;
    end
    rst = 1'b0; inv_req = 1'b0; s_ready = 1'b0; wtb_empty_in = 1'b1;

    // Lone master 1 write: wait (bounded) for the request to reach L2, then complete it.
    m_valid = 2'b10;
    got     = 1'b0;
    for (int c = 0; c < 5 && !got; c++) begin
      @(posedge clk);
      #1;
      got = s_valid;
    end
    chk("hs/vld", got, 1'b1);
    chk("hs/req", {s_addr, s_wdata, s_wstrb}, {A1, W1, S1});
    s_ready = 1'b1;
    s_rdata = 32'h5A5A1234;
    #1;
    chk("hs/rsp", {m_ready, m_rdata}, {2'b10, 32'h5A5A1234, 32'h0});
    @(posedge clk);
    #1;
    s_ready = 1'b0;
    m_valid = '0;
    @(negedge clk);
    chk("hs/idle", {s_valid, m_ready}, 3'b000);

`ifdef MERGE_CNT_EN
    // Counters were cleared by the mid-table reset: one completion each since then.
    chk("cnt/start", cnt_grant, {4'h1, 4'h1});
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #1;
      m_valid = 2'b01;
      got     = 1'b0;
      for (int c = 0; c < 4 && !got; c++) begin
        @(posedge clk);
        #1;
        got = s_valid;
      end
      chk("cnt/vld", got, 1'b1);
      s_ready = 1'b1;
      @(posedge clk);
      #1;
      s_ready = 1'b0;
      m_valid = '0;
    end
    chk("cnt/sat", cnt_grant, {4'h1, 4'hF});
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    chk("cnt/clr", cnt_grant, 8'h00);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
